// File: rtl/sort_pkg.sv
// Shared types for the sorting pipeline front end.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } src_state_t;

endpackage

// File: rtl/fifo2.sv
// Two-entry register FIFO; head is always presented on o_data.
module fifo2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_occ == 2'd0);
    assign o_full  = (r_occ == 2'd2);
    assign o_occ   = r_occ;

endmodule

// File: rtl/random_array_source.sv
// Requests ARRAY_LEN words from the LCG, keeps their top bits and streams them
// to the sorter with a last marker, then pulses done.
module random_array_source
    import sort_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned VALUE_WIDTH = 16,
    parameter int unsigned ARRAY_LEN   = 16,
    parameter int unsigned CNT_WIDTH   = $clog2(ARRAY_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   rnd_en,
    input  logic [DATA_WIDTH-1:0]  rnd_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VALUE_WIDTH-1:0] out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [CNT_WIDTH-1:0] LenC  = CNT_WIDTH'(ARRAY_LEN);
    localparam logic [CNT_WIDTH-1:0] LastC = CNT_WIDTH'(ARRAY_LEN - 1);

    src_state_t           r_state;
    src_state_t           w_state_next;
    logic [CNT_WIDTH-1:0] r_req_cnt;
    logic [CNT_WIDTH-1:0] r_emit_cnt;
    logic                 r_inflight;

    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic [1:0]           w_occ;
    logic                 w_room;
    logic                 w_unused_low;

    // Low LCG bits are statistically weak and deliberately dropped.
    assign w_unused_low = ^{rnd_in[DATA_WIDTH-VALUE_WIDTH-1:0], w_full};

    fifo2 #(
        .WIDTH(VALUE_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_data (rnd_in[DATA_WIDTH-1 -: VALUE_WIDTH]),
        .o_data (out_data),
        .o_empty(w_empty),
        .o_full (w_full),
        .o_occ  (w_occ)
    );

    assign out_valid = !w_empty;
    assign w_pop     = out_valid & out_ready;
    assign out_last  = out_valid & (r_emit_cnt == LastC);

    // Words already queued or in flight, minus this cycle's pop, must leave a free slot.
    assign w_room = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign rnd_en = (r_state == RUN) & (r_req_cnt < LenC) & w_room;

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_pop && out_last) w_state_next = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req_cnt  <= '0;
            r_emit_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= rnd_en;
            if (r_state == IDLE && start) begin
                r_req_cnt  <= '0;
                r_emit_cnt <= '0;
            end else if (r_state == RUN) begin
                if (rnd_en) r_req_cnt <= r_req_cnt + 1'b1;
                if (w_pop)  r_emit_cnt <= r_emit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_random_array_source.sv
// Directed bench: two instances (ARRAY_LEN 16 and 1) fed by a counting generator model.
module tb_random_array_source;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gen_clr = 1'b0;
    logic        sel = 1'b0;
    logic        start_s = 1'b0;
    logic        ready_s = 1'b1;

    logic        start_a, ready_a, en_a, valid_a, last_a, busy_a, done_a;
    logic [31:0] rnd_a;
    logic [15:0] data_a;
    logic        start_b, ready_b, en_b, valid_b, last_b, busy_b, done_b;
    logic [31:0] rnd_b;
    logic [15:0] data_b;

    logic        en_s, valid_s, last_s, busy_s, done_s;
    logic [15:0] data_s;

    int unsigned k_a = 1;
    int unsigned k_b = 1;
    int          n_tot = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    assign start_a = !sel && start_s;
    assign start_b = sel && start_s;
    assign ready_a = sel ? 1'b1 : ready_s;
    assign ready_b = sel ? ready_s : 1'b1;
    assign en_s    = sel ? en_b : en_a;
    assign valid_s = sel ? valid_b : valid_a;
    assign last_s  = sel ? last_b : last_a;
    assign busy_s  = sel ? busy_b : busy_a;
    assign done_s  = sel ? done_b : done_a;
    assign data_s  = sel ? data_b : data_a;

    random_array_source dut (
        .clk(clk), .rst(rst), .start(start_a), .rnd_en(en_a), .rnd_in(rnd_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a), .out_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    random_array_source #(.ARRAY_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_b), .rnd_en(en_b), .rnd_in(rnd_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .out_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    // Generator model: word k appears the cycle after the k-th rnd_en.
    always @(posedge clk) begin
        if (gen_clr) begin
            k_a <= 1;
            k_b <= 1;
        end else begin
            if (en_a) begin
                rnd_a <= {k_a[15:0], 16'h0};
                k_a   <= k_a + 1;
            end
            if (en_b) begin
                rnd_b <= {k_b[15:0], 16'h0};
                k_b   <= k_b + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int rel);
        case (mode)
            1:       return !(rel >= 3 && rel <= 10);
            2:       return (rel % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    logic [15:0] keys [32];
    int          hs_n, en_cnt, en_at10, done_cyc, busy_first, busy_last;
    int          last_cnt, last_idx, hold_bad;

    // Start in relative cycle 0 and log until done, max_cyc or stop_hs handshakes.
    task automatic run(input int mode, input int ign_cyc, input int max_cyc, input int stop_hs);
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        prev_last;
        hs_n = 0; en_cnt = 0; en_at10 = -1; done_cyc = -1; busy_first = -1; busy_last = -1;
        last_cnt = 0; last_idx = -1; hold_bad = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        @(posedge clk); #1;
        for (int rel = 0; rel < max_cyc && done_cyc < 0; rel++) begin
            start_s = (rel == 0) || (rel == ign_cyc);
            ready_s = rdy(mode, rel);
            @(negedge clk);
            if (en_s) en_cnt++;
            if (rel == 10) en_at10 = en_cnt;
            if (busy_s) begin
                if (busy_first < 0) busy_first = rel;
                busy_last = rel;
            end
            if (done_s) done_cyc = rel;
            if (prev_stall && (data_s !== prev_data || last_s !== prev_last)) hold_bad++;
            if (valid_s && ready_s) begin
                if (hs_n < 32) keys[hs_n] = data_s;
                if (last_s) begin
                    last_cnt++;
                    last_idx = hs_n;
                end
                hs_n++;
            end
            prev_stall = valid_s && !ready_s;
            prev_data  = data_s;
            prev_last  = last_s;
            if (stop_hs > 0 && hs_n == stop_hs) break;
            @(posedge clk); #1;
        end
        start_s = 1'b0;
        ready_s = 1'b1;
    endtask

    task automatic clear_gen();
        @(posedge clk); #1 gen_clr = 1'b1;
        @(posedge clk); #1 gen_clr = 1'b0;
    endtask

    task automatic check_keys(input string tag, input int first, input int n);
        check({tag, "_count"}, hs_n, n);
        for (int i = 0; i < n && i < hs_n; i++) check({tag, "_key"}, keys[i], first + i);
        check({tag, "_last_cnt"}, last_cnt, 1);
        check({tag, "_last_idx"}, last_idx, n - 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"}, en_a, 0);
        check({tag, "_valid"}, valid_a, 0);
        check({tag, "_last"}, last_a, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_data"}, data_a, 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_valid1", valid_b, 0);
        @(posedge clk); #1 rst = 1'b0;
        clear_gen();

        // Free-running, plus a start in the DONE cycle that must be ignored.
        run(0, 19, 40, 0);
        check_keys("free", 1, 16);
        check("free_done_cyc", done_cyc, 19);
        check("free_busy_first", busy_first, 1);
        check("free_busy_last", busy_last, 19);
        check("free_en_cnt", en_cnt, 16);
        @(negedge clk);
        check("free_no_restart_busy", busy_a, 0);
        check("free_no_restart_en", en_a, 0);

        // Backpressure in cycles 3..10.
        clear_gen();
        run(1, -1, 60, 0);
        check("bp_en_at10", en_at10, 2);
        check("bp_hold", hold_bad, 0);
        check_keys("bp", 1, 16);
        check("bp_done_cyc", done_cyc, 27);

        // Alternating ready.
        clear_gen();
        run(2, -1, 80, 0);
        check_keys("alt", 1, 16);
        check("alt_en_cnt", en_cnt, 16);
        check("alt_hold", hold_bad, 0);
        check("alt_done_seen", done_cyc >= 0, 1);

        // Reset right after the key-5 handshake; words 6 and 7 are lost.
        clear_gen();
        run(0, -1, 40, 5);
        check("rst_pre_hs", hs_n, 5);
        @(posedge clk); #1 rst = 1'b1;
        #1 check_idle_outputs("midrst");
        @(posedge clk); #1 rst = 1'b0;
        run(0, -1, 40, 0);
        check_keys("after_rst", 8, 16);
        check("after_rst_done_cyc", done_cyc, 19);

        // Start pulsed mid-run is ignored.
        clear_gen();
        run(0, 5, 40, 0);
        check_keys("ign", 1, 16);
        check("ign_done_cyc", done_cyc, 19);

        // ARRAY_LEN = 1.
        sel = 1'b1;
        clear_gen();
        run(0, -1, 20, 0);
        check_keys("len1", 1, 1);
        check("len1_en_cnt", en_cnt, 1);
        check("len1_done_cyc", done_cyc, 4);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/random_array_source.md
# random_array_source

Streams a fixed-length array of pseudo-random values into the sorter input. Sits directly downstream of the LCG random generator. On `start` it drives the generator's `enable`, captures each generated word, and truncates it to the sorter's key width. It presents exactly `ARRAY_LEN` keys on a valid/ready stream with a `last` marker, then pulses `done`.

## Interface
- `DATA_WIDTH`, 32, width of generator output word
- `VALUE_WIDTH`, 16, width of emitted key; must be ≤ `DATA_WIDTH`
- `ARRAY_LEN`, 16, keys per run; must be ≥ 1
- `CNT_WIDTH`, `$clog2(ARRAY_LEN+1)`, width of the request and emit counters
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to begin a run; sampled only in IDLE
- `rnd_en`  out  1  enable to generator; one new word is requested per asserted cycle
- `rnd_in`  in  `DATA_WIDTH`  generator output; valid on the cycle after the `rnd_en` cycle that requested it
- `out_valid`  out  1  key available
- `out_ready`  in  1  sorter accepts key
- `out_data`  out  `VALUE_WIDTH`  key = `rnd_in[DATA_WIDTH-1 -: VALUE_WIDTH]` (top bits; LCG low bits are weak)
- `out_last`  out  1  qualifies the final key of the run
- `busy`  out  1  high from the cycle after `start` until `done`
- `done`  out  1  one-cycle pulse after the last handshake

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on the handshake of the key with `out_last=1`.
  - DONE → IDLE unconditionally after one cycle. `done=1` only in DONE.
- `start` is ignored while in RUN or DONE.
- Counters:
  - `req_cnt` counts `rnd_en` cycles; capped at `ARRAY_LEN`.
  - `emit_cnt` counts handshakes (`out_valid & out_ready`).
  - Both clear on entry to RUN.
- Buffering: a 2-entry FIFO holds captured keys. `inflight` is a 1-bit flag, set in the cycle after an `rnd_en`.
- `rnd_en = RUN & (req_cnt < ARRAY_LEN) & (occupancy + inflight - pop < 2)`, where `pop` is the current-cycle handshake. This is combinational and never overflows the FIFO.
- Capture: when `inflight` is 1, the truncated `rnd_in` is pushed into the FIFO that cycle. The push is unconditional; space is guaranteed by the issue rule.
- Output: `out_valid = !fifo_empty`. `out_data` is the FIFO head. `out_last = out_valid & (emit_cnt == ARRAY_LEN-1)`.
- Backpressure: while `out_valid & !out_ready`, `out_data` and `out_last` hold stable. No keys are dropped or duplicated.
- Reset (any cycle, including mid-run):
  - State returns to IDLE; counters and FIFO clear; `inflight` clears.
  - Outputs become `rnd_en=0`, `out_valid=0`, `out_last=0`, `busy=0`, `done=0`, `out_data=0`.
  - A generator word in flight at reset is discarded.

## Timing
- `start` high in cycle 0 → RUN in cycle 1. `rnd_en` is first high in cycle 1, the word is captured in cycle 2, and `out_valid` is first high in cycle 3.
- With `out_ready` held at 1: one key per cycle, keys in cycles 3 … `ARRAY_LEN`+2, `done` in cycle `ARRAY_LEN`+3.
- After `out_ready` drops: at most 2 further `rnd_en` cycles, then `rnd_en` stays 0 until a pop.
- `ARRAY_LEN=1`: a single `rnd_en`, and the single key carries `out_last=1`.
- A back-to-back `start` asserted in the DONE cycle is ignored. `start` is accepted in the following (IDLE) cycle.

## Structure
- Shared package `sort_pkg`: state encoding `src_state_t` {IDLE, RUN, DONE}.
- One sub-module, `fifo2`: a 2-entry register FIFO with push, pop, head data, empty, full and 2-bit occupancy, reset by `rst`.
- Top level holds the FSM, counters, `inflight` and the issue logic.

## Test plan
For every scenario, the bench models the generator: `rnd_in <= {k, 16'h0}` on each `rnd_en`, with k = 1, 2, 3, ….

1. Free-running run: `ARRAY_LEN=16`, `out_ready=1`, `start` at cycle 0 → keys 1…16 in cycles 3–18, `out_last` only with key 16, `done` in cycle 19, `busy` high in cycles 1–19.
2. Backpressure: `out_ready=0` in cycles 3–10 → key 1 holds stable, total `rnd_en` pulses by cycle 10 = 2, then keys 1…16 in order with no gaps or duplicates.
3. Toggling ready: `out_ready` alternates 1/0 every cycle → 16 handshakes, order preserved, `rnd_en` count = 16 exactly.
4. Reset mid-run: `rst` asserted after key 5 handshake → all outputs 0 immediately. The next `start` yields keys beginning with the next generator value (7 or later) and a full 16-key run.
5. Ignored start and `ARRAY_LEN=1`: `start` pulsed during RUN has no effect. With `ARRAY_LEN=1`, one `rnd_en`, key 1 with `out_last=1`, and `done` in cycle 4.
